// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector.
// The pattern, its length (1..MAX_LEN) and the overlap mode can be loaded at run time.
// Input bits count only when in_valid is high.
// A registered one-cycle pulse marks each match, and a saturating counter tallies the matches.
// An illegal length latches cfg_err and disables detection until a legal load.
module seq_detect_prog #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_bit,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(4'b1011);
    localparam logic [LEN_W-1:0]   DEF_LEN = LEN_W'(4);
    localparam logic [LEN_W-1:0]   MAX_L   = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               err_q, err_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               seen_q, seen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic               beat;
    logic               hit;
    logic               cfg_legal;

    // Match evaluation for the current beat (only bits below len are compared)
    always_comb begin
        cand = {hist_q[MAX_LEN-2:0], inp_bit};
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len_q));
        end
        fill_inc  = {1'b0, fill_q} + 1'b1;
        beat      = in_valid & ~cfg_load & ~err_q;
        hit       = beat && (fill_inc >= {1'b0, len_q}) && (((cand ^ pat_q) & mask) == '0);
        cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_L);
    end

    // Next-state logic: config load, shift/fill update, pulse and counter
    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        err_d  = err_q;
        hist_d = hist_q;
        fill_d = fill_q;
        seen_d = 1'b0;
        cnt_d  = cnt_q;

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            err_d  = ~cfg_legal;
            hist_d = '0;
            fill_d = '0;
        end else if (beat) begin
            hist_d = cand;
            fill_d = (fill_q == MAX_L) ? fill_q : fill_q + 1'b1;
            if (hit && !ovl_q) begin
                fill_d = '0;
            end
            seen_d = hit;
        end

        if (count_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset to the default "1011" detector
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= DEF_PAT;
            len_q  <= DEF_LEN;
            ovl_q  <= 1'b1;
            err_q  <= 1'b0;
            hist_q <= '0;
            fill_q <= '0;
            seen_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            err_q  <= err_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            seen_q <= seen_d;
            cnt_q  <= cnt_d;
        end
    end

    assign seq_seen    = seen_q;
    assign match_count = cnt_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog, built with a 2-bit counter so that saturation is reachable.
module tb_seq_detect_prog;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned CNT_W   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               inp_bit;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clr;
    logic               seq_seen;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    int checks = 0;
    int errors = 0;

    seq_detect_prog #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .inp_bit    (inp_bit),
        .in_valid   (in_valid),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .count_clr  (count_clr),
        .seq_seen   (seq_seen),
        .match_count(match_count),
        .cfg_err    (cfg_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then sample just after the edge
    task automatic cyc(input logic b, input logic v);
        inp_bit  = b;
        in_valid = v;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        count_clr = 1'b0;
        cfg_load  = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic beat_chk(input string tag, input logic b, input logic exp_seen,
                            input logic [CNT_W-1:0] exp_cnt);
        cyc(b, 1'b1);
        chk({tag, "_seen"}, 32'(seq_seen), 32'(exp_seen));
        chk({tag, "_cnt"}, 32'(match_count), 32'(exp_cnt));
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        cyc(1'b1, 1'b1);
    endtask

    task automatic clr();
        count_clr = 1'b1;
        cyc(1'b0, 1'b0);
        chk("clr_cnt", 32'(match_count), 32'd0);
    endtask

    logic [3:0] pat1011;

    initial begin
        reset = 1'b1; inp_bit = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; count_clr = 1'b0;
        pat1011 = 4'b1011;

        // Reset defaults
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        chk("rst_seen", 32'(seq_seen), 32'd0);
        chk("rst_cnt", 32'(match_count), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);

        // Default 1011 overlapping: 1011011 -> pulses after bit 4 and 7
        beat_chk("ov1", 1'b1, 1'b0, 2'd0);
        beat_chk("ov2", 1'b0, 1'b0, 2'd0);
        beat_chk("ov3", 1'b1, 1'b0, 2'd0);
        beat_chk("ov4", 1'b1, 1'b1, 2'd1);
        beat_chk("ov5", 1'b0, 1'b0, 2'd1);
        beat_chk("ov6", 1'b1, 1'b0, 2'd1);
        beat_chk("ov7", 1'b1, 1'b1, 2'd2);
        cyc(1'b1, 1'b0);
        chk("ov_idle_seen", 32'(seq_seen), 32'd0);

        // Non-overlapping 1011: 1011011 -> one pulse; then 1011 -> second pulse
        clr();
        load(8'h0B, 4'd4, 1'b0);
        chk("load_err", 32'(cfg_err), 32'd0);
        chk("load_cnt", 32'(match_count), 32'd0);
        beat_chk("no1", 1'b1, 1'b0, 2'd0);
        beat_chk("no2", 1'b0, 1'b0, 2'd0);
        beat_chk("no3", 1'b1, 1'b0, 2'd0);
        beat_chk("no4", 1'b1, 1'b1, 2'd1);
        beat_chk("no5", 1'b0, 1'b0, 2'd1);
        beat_chk("no6", 1'b1, 1'b0, 2'd1);
        beat_chk("no7", 1'b1, 1'b0, 2'd1);
        beat_chk("no8", 1'b1, 1'b0, 2'd1);
        beat_chk("no9", 1'b0, 1'b0, 2'd1);
        beat_chk("no10", 1'b1, 1'b0, 2'd1);
        beat_chk("no11", 1'b1, 1'b1, 2'd2);

        // 8-bit pattern 11100101 with a 3-cycle valid gap after bit 4
        clr();
        load(8'b11100101, 4'd8, 1'b1);
        beat_chk("l8_1", 1'b1, 1'b0, 2'd0);
        beat_chk("l8_2", 1'b1, 1'b0, 2'd0);
        beat_chk("l8_3", 1'b1, 1'b0, 2'd0);
        beat_chk("l8_4", 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0);
            chk("l8_gap_seen", 32'(seq_seen), 32'd0);
        end
        beat_chk("l8_5", 1'b0, 1'b0, 2'd0);
        beat_chk("l8_6", 1'b1, 1'b0, 2'd0);
        beat_chk("l8_7", 1'b0, 1'b0, 2'd0);
        beat_chk("l8_8", 1'b1, 1'b1, 2'd1);

        // len=1 with bits above len set in the pattern; counter saturates at 3
        clr();
        load(8'hA5, 4'd1, 1'b1);
        beat_chk("sat1", 1'b1, 1'b1, 2'd1);
        beat_chk("sat2", 1'b1, 1'b1, 2'd2);
        beat_chk("sat3", 1'b1, 1'b1, 2'd3);
        beat_chk("sat4", 1'b1, 1'b1, 2'd3);
        beat_chk("sat5", 1'b1, 1'b1, 2'd3);
        beat_chk("sat_zero", 1'b0, 1'b0, 2'd3);
        count_clr = 1'b1;
        beat_chk("clr_hit", 1'b1, 1'b1, 2'd0);

        // Illegal lengths latch cfg_err and suppress matches
        load(8'h0B, 4'd0, 1'b1);
        chk("err_len0", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 20; i++) begin
            beat_chk("err_stream", pat1011[3 - (i % 4)], 1'b0, 2'd0);
        end
        chk("err_hold", 32'(cfg_err), 32'd1);
        load(8'h0B, 4'd4, 1'b1);
        chk("err_clear", 32'(cfg_err), 32'd0);
        load(8'h0B, 4'd9, 1'b1);
        chk("err_len9", 32'(cfg_err), 32'd1);
        beat_chk("e9_1", 1'b1, 1'b0, 2'd0);
        load(8'h0B, 4'd4, 1'b1);
        chk("err_clear2", 32'(cfg_err), 32'd0);
        beat_chk("res1", 1'b1, 1'b0, 2'd0);
        beat_chk("res2", 1'b0, 1'b0, 2'd0);
        beat_chk("res3", 1'b1, 1'b0, 2'd0);
        beat_chk("res4", 1'b1, 1'b1, 2'd1);

        // Non-overlap load, 101, then a mid-stream reset restores defaults
        load(8'h0B, 4'd4, 1'b0);
        beat_chk("mr1", 1'b1, 1'b0, 2'd1);
        beat_chk("mr2", 1'b0, 1'b0, 2'd1);
        beat_chk("mr3", 1'b1, 1'b0, 2'd1);
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        chk("mr_rst_seen", 32'(seq_seen), 32'd0);
        chk("mr_rst_cnt", 32'(match_count), 32'd0);
        chk("mr_rst_err", 32'(cfg_err), 32'd0);
        beat_chk("mr4", 1'b1, 1'b0, 2'd0);
        beat_chk("mr5", 1'b1, 1'b0, 2'd0);
        beat_chk("mr6", 1'b0, 1'b0, 2'd0);
        beat_chk("mr7", 1'b1, 1'b0, 2'd0);
        beat_chk("mr8", 1'b1, 1'b1, 2'd1);
        // Default overlap after reset: 011 completes 1011 again
        beat_chk("mr9", 1'b0, 1'b0, 2'd1);
        beat_chk("mr10", 1'b1, 1'b0, 2'd1);
        beat_chk("mr11", 1'b1, 1'b1, 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
